// File: rtl/game_pkg.sv
// game_pkg: shared encodings and bit indices for the player motion logic
package game_pkg;
  localparam int CW = 13;
  typedef enum logic [1:0] {
    VS_GROUND = 2'd0,
    VS_RISE   = 2'd1,
    VS_FALL   = 2'd2
  } vstate_e;
  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_JUMP   = 2;
  localparam int FREE_UP    = 0;
  localparam int FREE_DOWN  = 1;
  localparam int FREE_RIGHT = 2;
  localparam int FREE_LEFT  = 3;
endpackage

// File: rtl/tick_edge_det.sv
// tick_edge_det: rising-edge detector whose history only advances on tick
module tick_edge_det #(
  parameter logic PREV_RST = 1'b1
) (
  input  logic clk,
  input  logic iRST_N,
  input  logic iTick,
  input  logic d,
  output logic pulse
);
  logic prev;
  always_ff @(posedge clk or negedge iRST_N) begin
    if (!iRST_N) prev <= PREV_RST;
    else if (iTick) prev <= d;
  end
  assign pulse = d & ~prev;
endmodule

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: tick-gated player walk/scroll and GROUND/RISE/FALL jump control
module player_motion_ctrl
  import game_pkg::*;
#(
  parameter logic [CW-1:0] SCROLL_X   = 13'd300,
  parameter logic [CW-1:0] JUMP_TICKS = 13'd150,
  parameter logic [CW-1:0] Y_RESET    = 13'd64,
  parameter logic [CW-1:0] MAP_MAX    = 13'h1FFF
) (
  input  logic          clk,
  input  logic          iRST_N,
  input  logic          iTick,
  input  logic [3:0]    iBtn_state,
  input  logic [3:0]    iFree,
  output logic [CW-1:0] oPlayer_X,
  output logic [CW-1:0] oPlayer_Y,
  output logic [CW-1:0] oMap_X,
  output logic          oDirection,
  output logic [1:0]    oVstate
);
  vstate_e vs, vs_n;
  logic [CW-1:0] x, x_n, y, y_n, map, map_n, cnt, cnt_n;
  logic dir, dir_n, jump_edge, go_right, go_left, rise_ok;
  logic unused_btn;
  assign unused_btn = iBtn_state[3];
  // a jump held through reset must be released before it counts as a press
  tick_edge_det #(.PREV_RST(1'b1)) u_jump_edge (
    .clk   (clk),
    .iRST_N(iRST_N),
    .iTick (iTick),
    .d     (iBtn_state[BTN_JUMP]),
    .pulse (jump_edge)
  );
  always_ff @(posedge clk or negedge iRST_N) begin
    if (!iRST_N) begin
      vs  <= VS_FALL;
      x   <= '0;
      y   <= Y_RESET;
      map <= '0;
      cnt <= '0;
      dir <= 1'b1;
    end else if (iTick) begin
      vs  <= vs_n;
      x   <= x_n;
      y   <= y_n;
      map <= map_n;
      cnt <= cnt_n;
      dir <= dir_n;
    end
  end
  always_comb begin
    go_right = iBtn_state[BTN_RIGHT] & iFree[FREE_RIGHT];
    go_left  = iBtn_state[BTN_LEFT] & iFree[FREE_LEFT] & (x != '0);
    x_n      = go_right ? (x < SCROLL_X ? x + 13'd1 : x) : go_left ? x - 13'd1 : x;
    map_n    = (go_right && x >= SCROLL_X && map < MAP_MAX) ? map + 13'd1 : map;
    dir_n    = go_right ? 1'b1 : go_left ? 1'b0 : dir;
    rise_ok  = iFree[FREE_UP] & iBtn_state[BTN_JUMP] & (cnt < JUMP_TICKS);
    vs_n     = vs;
    y_n      = y;
    cnt_n    = cnt;
    case (vs)
      VS_GROUND: begin
        vs_n  = jump_edge ? VS_RISE : iFree[FREE_DOWN] ? VS_FALL : VS_GROUND;
        cnt_n = jump_edge ? '0 : cnt;
      end
      VS_RISE: begin
        vs_n  = rise_ok ? VS_RISE : VS_FALL;
        y_n   = rise_ok ? y + 13'd1 : y;
        cnt_n = rise_ok ? cnt + 13'd1 : cnt;
      end
      VS_FALL: begin
        vs_n = (iFree[FREE_DOWN] && y != '0) ? VS_FALL : VS_GROUND;
        y_n  = (iFree[FREE_DOWN] && y != '0) ? y - 13'd1 : y;
      end
      default: vs_n = VS_FALL;
    endcase
  end
  assign oPlayer_X  = x;
  assign oPlayer_Y  = y;
  assign oMap_X     = map;
  assign oDirection = dir;
  assign oVstate    = vs;
endmodule
